pwm_ramp_ctrl: RTL
==================

// Module: pwm_ramp_ctrl
// PURPOSE
//  Bus-master sequencer for the PWM peripheral's 8-bit register bus.
//  Ramps duty cycle from its current value to a target in fixed steps, one step per interval.
//  Enables the PWM (ctl0) at the start of each ramp, then writes duty high and duty low per step.
//  Sits between the host/fade logic and the pwm slave; replaces direct host writes for fades.
// PARAMETERS
//  PWM_BITS  10     duty width; must match the pwm slave (9..16)
//  CNT_BITS  16     interval counter width
//  ADDR_CTL  8'h00  ctl0 register address
//  ADDR_DHI  8'h01  duty[PWM_BITS-1:8] register address
//  ADDR_DLO  8'h10  duty[7:0] register address
// PORTS
//  clk_i        in   1         clock
//  nrst_i       in   1         synchronous reset, active low
//  start_i      in   1         pulse: latch target/step/interval/ss, begin or retarget ramp
//  abort_i      in   1         pulse: stop ramp; wins over a simultaneous start_i
//  target_i     in   PWM_BITS  target duty
//  step_i       in   PWM_BITS  duty increment per step (0 treated as 1)
//  interval_i   in   CNT_BITS  wait between steps: WAIT lasts interval+1 cycles
//  ss_i         in   2         ctl0[1:0] dither shift written at ramp start
//  m_addr_o     out  8         register address to pwm
//  m_data_o     out  8         write data to pwm
//  m_event_o    out  2         [1]=write strobe (1 cycle), [0]=read, always 0
//  busy_o       out  1         high from the cycle after an accepted start_i until return to IDLE
//  done_o       out  1         1-cycle pulse when target is reached (not on abort)
//  cur_duty_o   out  PWM_BITS  last duty fully written (updated with the DLO write)
// BEHAVIOUR
//  Reset (nrst_i=0 at clk edge): all outputs 0, FSM=IDLE, cur_duty=0; applies mid-write too.
//  All outputs registered. m_event_o=2'b10 only in CTL/WR_HI/WR_LO; else addr/data/event=0.
//  FSM (one cycle per state except WAIT):
//   IDLE : start_i & !abort_i -> latch inputs -> CTL
//   CTL  : write ADDR_CTL, data {1'b1,5'b0,ss}; cnt<=interval -> WAIT
//   WAIT : cnt==0 -> (cur==target ? IDLE+done : WR_HI); else cnt--
//   WR_HI: nxt computed; write ADDR_DHI, data {zero-pad, nxt[PWM_BITS-1:8]} -> WR_LO
//   WR_LO: write ADDR_DLO, data nxt[7:0]; cur<=nxt;
//          nxt==target ? IDLE + done_o next cycle : WAIT (cnt<=interval)
//  Step arithmetic, PWM_BITS+1 wide, no wrap:
//   cur<target: nxt=min(cur+step,target); cur>target: nxt=max(cur-step,target).
//  HI always precedes LO, on consecutive cycles; the pair is never split.
//  start_i while busy (not abort): relatch target/step/interval/ss; no ctl0 rewrite;
//   current WAIT count runs out unchanged; new values apply from the next nxt/reload.
//  abort_i in CTL/WAIT -> IDLE next cycle; in WR_HI -> finish WR_LO, then IDLE; no done_o.
//  abort_i in IDLE: no effect. The PWM stays enabled after abort.
//  start_i with target==cur: CTL write, one WAIT, then IDLE + done_o; no duty writes.
// TESTING
//  1 reset, cur=0, start target=10 step=4 interval=3 ss=2 -> T1 write 00<=8'h82;
//    WAIT T2-T5; T6 01<=00, T7 10<=04; then duties 8, 10; done_o once; cur_duty_o=10.
//  2 from cur=10, start target=0 step=3 interval=0 -> duty writes 7,4,1,0; a 1-cycle WAIT
//    between pairs; done_o after last.
//  3 start target=600 step=0 from 598 -> writes 599 (01<=02,10<=57), then 600
//    (01<=02,10<=58); HI always one cycle before LO.
//  4 mid-ramp 0->100 step 10, retarget to 20 after duty 30 -> next writes 20; done_o;
//    no second ctl0 write.
//  5 abort during WR_HI -> WR_LO still issued; IDLE; done_o=0; start+abort same cycle
//    in IDLE -> stays IDLE.
//  6 nrst_i low during WAIT -> next edge all outputs 0, cur_duty_o=0; start after release
//    works normally.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Bus-master sequencer that ramps the PWM duty register toward a target in fixed steps,
// enabling ctl0 at ramp start and writing duty high/low as an unsplit pair per step.
module pwm_ramp_ctrl #(
  parameter int unsigned PWM_BITS = 10,
  parameter int unsigned CNT_BITS = 16,
  parameter logic [7:0]  ADDR_CTL = 8'h00,
  parameter logic [7:0]  ADDR_DHI = 8'h01,
  parameter logic [7:0]  ADDR_DLO = 8'h10
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [PWM_BITS-1:0] target_i,
  input  logic [PWM_BITS-1:0] step_i,
  input  logic [CNT_BITS-1:0] interval_i,
  input  logic [1:0]          ss_i,
  output logic [7:0]          m_addr_o,
  output logic [7:0]          m_data_o,
  output logic [1:0]          m_event_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [PWM_BITS-1:0] cur_duty_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTL,
    S_WAIT,
    S_WR_HI,
    S_WR_LO
  } state_e;

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] tgt_q, tgt_d;
  logic [PWM_BITS-1:0] step_q, step_d;
  logic [CNT_BITS-1:0] ival_q, ival_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] cur_q, cur_d;
  logic [PWM_BITS-1:0] nxt_q, nxt_d;
  logic                abort_pend_q, abort_pend_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                wr_q, wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [PWM_BITS-1:0] eff_step;
  logic [PWM_BITS:0]   up_sum;
  logic [PWM_BITS:0]   dn_diff;
  logic [PWM_BITS-1:0] nxt_calc;

  // Next duty: one step toward the target, clamped so it never overshoots or wraps
  always_comb begin
    eff_step = (step_q == '0) ? PWM_BITS'(1) : step_q;
    up_sum   = {1'b0, cur_q} + {1'b0, eff_step};
    dn_diff  = {1'b0, cur_q} - {1'b0, eff_step};
    nxt_calc = cur_q;
    if (cur_q < tgt_q) begin
      nxt_calc = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[PWM_BITS-1:0];
    end else if (cur_q > tgt_q) begin
      nxt_calc = (dn_diff[PWM_BITS] || (dn_diff < {1'b0, tgt_q})) ? tgt_q
                                                                  : dn_diff[PWM_BITS-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    step_d       = step_q;
    ival_d       = ival_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    nxt_d        = nxt_q;
    abort_pend_d = abort_pend_q;
    addr_d       = 8'h00;
    data_d       = 8'h00;
    wr_d         = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          tgt_d   = target_i;
          step_d  = step_i;
          ival_d  = interval_i;
          state_d = S_CTL;
          addr_d  = ADDR_CTL;
          data_d  = {1'b1, 5'b00000, ss_i};
          wr_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_CTL: begin
        cnt_d   = ival_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end else if (cur_q == tgt_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          nxt_d   = nxt_calc;
          state_d = S_WR_HI;
          addr_d  = ADDR_DHI;
          data_d  = 8'(nxt_calc[PWM_BITS-1:8]);
          wr_d    = 1'b1;
        end
      end
      S_WR_HI: begin
        cur_d   = nxt_q;
        state_d = S_WR_LO;
        addr_d  = ADDR_DLO;
        data_d  = nxt_q[7:0];
        wr_d    = 1'b1;
      end
      S_WR_LO: begin
        abort_pend_d = 1'b0;
        if (abort_pend_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (nxt_q == tgt_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = ival_q;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Retarget while busy leaves the running wait count and ctl0 untouched
    if (start_i && !abort_i && (state_q != S_IDLE)) begin
      tgt_d  = target_i;
      step_d = step_i;
      ival_d = interval_i;
    end

    // Abort never splits a duty pair: from WR_HI the LO write still goes out
    if (abort_i) begin
      unique case (state_q)
        S_CTL, S_WAIT, S_WR_LO: begin
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b0;
          addr_d       = 8'h00;
          data_d       = 8'h00;
          wr_d         = 1'b0;
          abort_pend_d = 1'b0;
        end
        S_WR_HI: abort_pend_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q      <= S_IDLE;
      tgt_q        <= '0;
      step_q       <= '0;
      ival_q       <= '0;
      cnt_q        <= '0;
      cur_q        <= '0;
      nxt_q        <= '0;
      abort_pend_q <= 1'b0;
      addr_q       <= 8'h00;
      data_q       <= 8'h00;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      step_q       <= step_d;
      ival_q       <= ival_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      abort_pend_q <= abort_pend_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign m_addr_o   = addr_q;
  assign m_data_o   = data_q;
  assign m_event_o  = {wr_q, 1'b0};
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cur_duty_o = cur_q;

endmodule
